// File: rtl/sub3_pkg.sv
// Shared types and helpers for the sub3 round-robin channel merger.
// Optional grant counters are enabled with SUB3_GNT_CNT_EN.
package sub3_pkg;

  localparam int GNT_CNT_W = 16;

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } out_state_e;

  function automatic int ch_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/sub3_skid.sv
// Two-entry per-channel buffer: head/tail registers with occupancy count.
// Part of sub3_arb; SUB3_GNT_CNT_EN does not affect this module.
module sub3_skid #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic         rdy,
  output logic         vld,
  output logic [W-1:0] dout
);

  logic [1:0]   cnt_reg;
  logic [W-1:0] head_reg;
  logic [W-1:0] tail_reg;
  logic         push_ok;
  logic         pop_ok;

  assign rdy     = (cnt_reg != 2'd2);
  assign vld     = (cnt_reg != 2'd0);
  assign dout    = head_reg;
  assign push_ok = push & rdy;
  assign pop_ok  = pop & vld;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_reg  <= 2'd0;
      head_reg <= '0;
      tail_reg <= '0;
    end else begin
      case ({push_ok, pop_ok})
        2'b10: begin
          if (cnt_reg == 2'd0) head_reg <= din;
          else                 tail_reg <= din;
          cnt_reg <= cnt_reg + 2'd1;
        end
        2'b01: begin
          head_reg <= tail_reg;
          cnt_reg  <= cnt_reg - 2'd1;
        end
        2'b11: begin
          // Occupancy unchanged; the new beat goes behind whatever remains.
          if (cnt_reg == 2'd1) begin
            head_reg <= din;
          end else begin
            head_reg <= tail_reg;
            tail_reg <= din;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/sub3_arb.sv
// Round-robin merger of N_CH buffered input channels into one registered output.
// Define SUB3_GNT_CNT_EN to add saturating per-channel grant counters (gnt_cnt).
module sub3_arb
  import sub3_pkg::*;
#(
  parameter int N_CH = 3,
  parameter int W    = 8,
  parameter int CH_W = ch_w(N_CH)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [N_CH-1:0]        in_vld,
  output logic [N_CH-1:0]        in_rdy,
  input  logic [0:N_CH-1][W-1:0] in_data,
  output logic                   out_vld,
  input  logic                   out_rdy,
  output logic [W-1:0]           out_data,
  output logic [CH_W-1:0]        out_ch
`ifdef SUB3_GNT_CNT_EN
  ,
  output logic [0:N_CH-1][GNT_CNT_W-1:0] gnt_cnt
`endif
);

  localparam logic [CH_W:0]   N_CH_EXT = (CH_W + 1)'(N_CH);
  localparam logic [CH_W-1:0] LAST_CH  = CH_W'(N_CH - 1);

  out_state_e      state_reg;
  logic [CH_W-1:0] rr_reg;
  logic [CH_W-1:0] rr_next;
  logic [W-1:0]    out_data_reg;
  logic [CH_W-1:0] out_ch_reg;

  logic [N_CH-1:0] buf_vld;
  logic [N_CH-1:0] pop;
  logic [W-1:0]    head_data [N_CH];

  logic            can_load;
  logic            found;
  logic [CH_W-1:0] win;
  logic [CH_W:0]   idx;

  for (genvar gi = 0; gi < N_CH; gi++) begin : g_ch
    sub3_skid #(.W(W)) u_skid (
      .clk  (clk),
      .rst  (rst),
      .push (in_vld[gi]),
      .pop  (pop[gi]),
      .din  (in_data[gi]),
      .rdy  (in_rdy[gi]),
      .vld  (buf_vld[gi]),
      .dout (head_data[gi])
    );
    assign pop[gi] = can_load & found & (win == CH_W'(gi));
  end

  assign can_load = (state_reg == EMPTY) | out_rdy;

  // First non-empty channel at or after rr, wrapping modulo N_CH.
  always_comb begin
    found = 1'b0;
    win   = '0;
    idx   = '0;
    for (int k = 0; k < N_CH; k++) begin
      idx = {1'b0, rr_reg} + (CH_W + 1)'(k);
      if (idx >= N_CH_EXT) idx = idx - N_CH_EXT;
      if (!found && buf_vld[idx[CH_W-1:0]]) begin
        found = 1'b1;
        win   = idx[CH_W-1:0];
      end
    end
  end

  assign rr_next = (win == LAST_CH) ? '0 : win + 1'b1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg    <= EMPTY;
      rr_reg       <= '0;
      out_data_reg <= '0;
      out_ch_reg   <= '0;
    end else if (can_load) begin
      if (found) begin
        state_reg    <= FULL;
        out_data_reg <= head_data[win];
        out_ch_reg   <= win;
        rr_reg       <= rr_next;
      end else begin
        state_reg <= EMPTY;
      end
    end
  end

  assign out_vld  = (state_reg == FULL);
  assign out_data = out_data_reg;
  assign out_ch   = out_ch_reg;

`ifdef SUB3_GNT_CNT_EN
  for (genvar gi = 0; gi < N_CH; gi++) begin : g_cnt
    logic [GNT_CNT_W-1:0] gnt_cnt_reg;
    always_ff @(posedge clk or posedge rst) begin
      if (rst)
        gnt_cnt_reg <= '0;
      else if (pop[gi] && (gnt_cnt_reg != '1))
        gnt_cnt_reg <= gnt_cnt_reg + 1'b1;
    end
    assign gnt_cnt[gi] = gnt_cnt_reg;
  end
`endif

endmodule

// File: tb/tb_sub3_arb.sv
// Directed testbench for sub3_arb (N_CH=3, W=8); grant-counter test needs SUB3_GNT_CNT_EN.
module tb_sub3_arb;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic [2:0]       in_vld;
  logic [2:0]       in_rdy;
  logic [0:2][7:0]  in_data;
  logic             out_vld;
  logic             out_rdy;
  logic [7:0]       out_data;
  logic [1:0]       out_ch;
`ifdef SUB3_GNT_CNT_EN
  logic [0:2][15:0] gnt_cnt;
`endif

  int errors = 0;
  int checks = 0;

  sub3_arb #(.N_CH(3), .W(8)) dut (
    .clk      (clk),
    .rst      (rst),
    .in_vld   (in_vld),
    .in_rdy   (in_rdy),
    .in_data  (in_data),
    .out_vld  (out_vld),
    .out_rdy  (out_rdy),
    .out_data (out_data),
    .out_ch   (out_ch)
`ifdef SUB3_GNT_CNT_EN
    ,
    .gnt_cnt  (gnt_cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    in_vld  = '0;
    in_data = '0;
    out_rdy = 1'b1;
    rst     = 1'b1;
    step();
    step();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    in_vld  = '0;
    in_data = '0;
    out_rdy = 1'b1;
    #2 rst = 1'b1;
    #3;
    checks++;
    if ({out_vld, out_ch, out_data, in_rdy} !== {1'b0, 2'd0, 8'h00, 3'b111}) begin
      errors++;
      $display("FAIL reset_state: got vld=%b ch=%0d data=%h rdy=%b want vld=0 ch=0 data=00 rdy=111",
               out_vld, out_ch, out_data, in_rdy);
    end
    step();
    rst = 1'b0;
    step();
    checks++;
    if (out_vld !== 1'b0) begin
      errors++;
      $display("FAIL reset_idle: got out_vld=%b want 0", out_vld);
    end
    $display("test_reset done");
  endtask

  task automatic test_single();
    do_reset();
    in_vld     = 3'b010;
    in_data[1] = 8'hA5;
    step();
    in_vld = '0;
    checks++;
    if ({out_vld, in_rdy} !== {1'b0, 3'b111}) begin
      errors++;
      $display("FAIL single_lat1: got vld=%b rdy=%b want vld=0 rdy=111", out_vld, in_rdy);
    end
    step();
    checks++;
    if ({out_vld, out_ch, out_data} !== {1'b1, 2'd1, 8'hA5}) begin
      errors++;
      $display("FAIL single_out: got vld=%b ch=%0d data=%h want vld=1 ch=1 data=a5",
               out_vld, out_ch, out_data);
    end
    checks++;
    if (in_rdy !== 3'b111) begin
      errors++;
      $display("FAIL single_rdy: got %b want 111", in_rdy);
    end
    step();
    checks++;
    if (out_vld !== 1'b0) begin
      errors++;
      $display("FAIL single_drain: got out_vld=%b want 0", out_vld);
    end
    $display("test_single done");
  endtask

  task automatic test_round_robin();
    logic [5:0] seq [3];
    logic [5:0] exp_seq [3];
    logic [1:0] exp_ch;
    logic [7:0] exp_data;
    do_reset();
    for (int i = 0; i < 3; i++) begin
      seq[i]     = 6'd0;
      exp_seq[i] = 6'd0;
      in_data[i] = {i[1:0], 6'd0};
    end
    out_rdy = 1'b1;
    in_vld  = 3'b111;
    exp_ch  = 2'd0;
    for (int cyc = 0; cyc < 20; cyc++) begin
      if (cyc >= 2) begin
        exp_data = {exp_ch, exp_seq[exp_ch]};
        checks++;
        if ({out_vld, out_ch, out_data} !== {1'b1, exp_ch, exp_data}) begin
          errors++;
          $display("FAIL rr_beat%0d: got vld=%b ch=%0d data=%h want vld=1 ch=%0d data=%h",
                   cyc, out_vld, out_ch, out_data, exp_ch, exp_data);
        end
        exp_seq[exp_ch] = exp_seq[exp_ch] + 6'd1;
        exp_ch = (exp_ch == 2'd2) ? 2'd0 : exp_ch + 2'd1;
      end
      for (int i = 0; i < 3; i++)
        if (in_vld[i] && in_rdy[i]) seq[i] = seq[i] + 6'd1;
      step();
      for (int i = 0; i < 3; i++) in_data[i] = {i[1:0], seq[i]};
    end
    in_vld = '0;
    step();
    $display("test_round_robin done");
  endtask

  task automatic test_backpressure();
    do_reset();
    out_rdy    = 1'b0;
    in_vld     = 3'b001;
    in_data[0] = 8'h10;
    step();
    in_data[0] = 8'h11;
    step();
    checks++;
    if ({out_vld, out_data} !== {1'b1, 8'h10}) begin
      errors++;
      $display("FAIL bp_first: got vld=%b data=%h want vld=1 data=10", out_vld, out_data);
    end
    in_data[0] = 8'h12;
    step();
    checks++;
    if (in_rdy[0] !== 1'b0) begin
      errors++;
      $display("FAIL bp_rdy_drop: got in_rdy0=%b want 0", in_rdy[0]);
    end
    in_data[0] = 8'h13;
    step();
    checks++;
    if ({in_rdy[0], out_vld, out_data} !== {1'b0, 1'b1, 8'h10}) begin
      errors++;
      $display("FAIL bp_stable: got rdy0=%b vld=%b data=%h want rdy0=0 vld=1 data=10",
               in_rdy[0], out_vld, out_data);
    end
    in_vld  = '0;
    out_rdy = 1'b1;
    step();
    checks++;
    if ({out_vld, out_data, in_rdy[0]} !== {1'b1, 8'h11, 1'b1}) begin
      errors++;
      $display("FAIL bp_drain1: got vld=%b data=%h rdy0=%b want vld=1 data=11 rdy0=1",
               out_vld, out_data, in_rdy[0]);
    end
    step();
    checks++;
    if ({out_vld, out_data} !== {1'b1, 8'h12}) begin
      errors++;
      $display("FAIL bp_drain2: got vld=%b data=%h want vld=1 data=12", out_vld, out_data);
    end
    step();
    checks++;
    if (out_vld !== 1'b0) begin
      errors++;
      $display("FAIL bp_empty: got out_vld=%b want 0", out_vld);
    end
    $display("test_backpressure done");
  endtask

  task automatic test_wrap();
    do_reset();
    out_rdy    = 1'b1;
    in_vld     = 3'b100;
    in_data[2] = 8'h2C;
    step();
    in_vld = '0;
    step();
    checks++;
    if ({out_vld, out_ch, out_data} !== {1'b1, 2'd2, 8'h2C}) begin
      errors++;
      $display("FAIL wrap_grant: got vld=%b ch=%0d data=%h want vld=1 ch=2 data=2c",
               out_vld, out_ch, out_data);
    end
    in_vld     = 3'b110;
    in_data[1] = 8'h1B;
    in_data[2] = 8'h2D;
    step();
    in_vld = '0;
    checks++;
    if (out_vld !== 1'b0) begin
      errors++;
      $display("FAIL wrap_gap: got out_vld=%b want 0", out_vld);
    end
    step();
    checks++;
    if ({out_vld, out_ch, out_data} !== {1'b1, 2'd1, 8'h1B}) begin
      errors++;
      $display("FAIL wrap_rr0: got vld=%b ch=%0d data=%h want vld=1 ch=1 data=1b",
               out_vld, out_ch, out_data);
    end
    step();
    checks++;
    if ({out_vld, out_ch, out_data} !== {1'b1, 2'd2, 8'h2D}) begin
      errors++;
      $display("FAIL wrap_next: got vld=%b ch=%0d data=%h want vld=1 ch=2 data=2d",
               out_vld, out_ch, out_data);
    end
    $display("test_wrap done");
  endtask

  task automatic test_mid_reset();
    do_reset();
    out_rdy = 1'b0;
    in_vld  = 3'b111;
    for (int b = 0; b < 3; b++) begin
      in_data[0] = 8'hA0 + 8'(b);
      in_data[1] = 8'hB0 + 8'(b);
      in_data[2] = 8'hC0 + 8'(b);
      step();
    end
    in_vld = '0;
    checks++;
    if ({out_vld, out_data, in_rdy} !== {1'b1, 8'hA0, 3'b000}) begin
      errors++;
      $display("FAIL mrst_full: got vld=%b data=%h rdy=%b want vld=1 data=a0 rdy=000",
               out_vld, out_data, in_rdy);
    end
    #1 rst = 1'b1;
    #1;
    checks++;
    if ({out_vld, in_rdy, out_ch, out_data} !== {1'b0, 3'b111, 2'd0, 8'h00}) begin
      errors++;
      $display("FAIL mrst_async: got vld=%b rdy=%b ch=%0d data=%h want vld=0 rdy=111 ch=0 data=00",
               out_vld, in_rdy, out_ch, out_data);
    end
    step();
    rst     = 1'b0;
    out_rdy = 1'b1;
    for (int c = 0; c < 5; c++) begin
      step();
      checks++;
      if (out_vld !== 1'b0) begin
        errors++;
        $display("FAIL mrst_stale%0d: got out_vld=%b data=%h want out_vld=0", c, out_vld, out_data);
      end
    end
    $display("test_mid_reset done");
  endtask

`ifdef SUB3_GNT_CNT_EN
  task automatic test_gnt_cnt();
    do_reset();
    out_rdy    = 1'b1;
    in_data[1] = 8'h11;
    in_data[2] = 8'h22;
    in_vld     = 3'b010;
    for (int c = 0; c < 3; c++) step();
    in_vld = 3'b100;
    for (int c = 0; c < 5; c++) step();
    in_vld = '0;
    for (int c = 0; c < 4; c++) step();
    checks++;
    if (gnt_cnt !== {16'd0, 16'd3, 16'd5}) begin
      errors++;
      $display("FAIL gnt_small: got %0d/%0d/%0d want 0/3/5", gnt_cnt[0], gnt_cnt[1], gnt_cnt[2]);
    end
    in_vld     = 3'b001;
    in_data[0] = 8'h5A;
    for (int c = 0; c < 70000; c++) step();
    in_vld = '0;
    for (int c = 0; c < 4; c++) step();
    checks++;
    if (gnt_cnt !== {16'hFFFF, 16'd3, 16'd5}) begin
      errors++;
      $display("FAIL gnt_sat: got %h/%0d/%0d want ffff/3/5", gnt_cnt[0], gnt_cnt[1], gnt_cnt[2]);
    end
    $display("test_gnt_cnt done");
  endtask
`endif

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_backpressure();
    test_wrap();
    test_mid_reset();
`ifdef SUB3_GNT_CNT_EN
    test_gnt_cnt();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/sub3_arb.md
# sub3_arb

Parametrised successor to the fixed-width flattened-port submodule: merges `N_CH` independent `W`-bit input channels into one output stream using round-robin arbitration. Each channel is buffered in a 2-entry skid buffer, and the output has a registered valid/ready stage. Sits between multi-lane producers (packed-array buses) and a single-lane consumer; replaces hand-flattened per-lane ports with packed-array ports sized by parameter.

## Interface
- `N_CH`, default 3: number of input channels, legal range 2..16.
- `W`, default 8: data width per channel, legal range 1..64.
- `CH_W`, default `sub3_pkg::ch_w(N_CH)`: channel-id width, equal to max(1, clog2(N_CH)). Derived; not overridden.

Ports:
- `clk`, in, 1: sole clock; all state updates on the rising edge.
- `rst`, in, 1: asynchronous, active-high reset.
- `in_vld`, in, `N_CH`: per-channel valid.
- `in_rdy`, out, `N_CH`: per-channel ready.
- `in_data`, in, `[0:N_CH-1][W-1:0]` (packed): per-channel data; element `i` belongs to channel `i`.
- `out_vld`, out, 1: output valid.
- `out_rdy`, in, 1: output ready.
- `out_data`, out, `W`: output data.
- `out_ch`, out, `CH_W`: source channel of `out_data`.
- `gnt_cnt`, out, `[0:N_CH-1][15:0]`: per-channel grant counters. Present only with `SUB3_GNT_CNT_EN`.

## Operation
- **Channel buffer.** Each channel has a 2-entry FIFO with occupancy `cnt` in {0,1,2}.
  - `in_rdy[i] = (cnt_i != 2)`, decoded from registered state only; there is no combinational path from `out_rdy`.
  - A push occurs when `in_vld[i] & in_rdy[i]`.
- **Output stage.** Two states:
  - `EMPTY`: `out_vld=0`.
  - `FULL`: `out_vld=1`.
  - The stage can load when it is `EMPTY`, or when it is `FULL` and `out_rdy=1` (drain and reload in the same cycle).
- **Arbitration.** Performed only when the stage can load.
  - Candidates are channels with `cnt_i != 0`.
  - Search starts at pointer `rr`, ascending with wrap-around modulo `N_CH`.
  - The winner is popped; its data and index are loaded into `out_data`/`out_ch`; `rr` is set to `(winner+1) mod N_CH`.
  - With no candidates: `FULL` with `out_rdy=1` goes to `EMPTY`; `rr` is unchanged.
- **Stability.** While `out_vld & !out_rdy`, `out_data`, `out_ch` and all buffer pops are frozen.
- **Simultaneous push and pop on one channel.** Legal when `cnt=1`, and `cnt` stays 1. When `cnt=2`, push is blocked by `in_rdy=0`.
- **Ordering.** Order within a channel is preserved. No ordering is guaranteed across channels.
- **Reset** (asynchronous assert; release takes effect at the next edge):
  - All `cnt=0`, `rr=0`, state `EMPTY`.
  - Outputs: `out_vld=0`, `out_data=0`, `out_ch=0`, `in_rdy` all 1, `gnt_cnt` all 0.
  - Reset mid-transfer discards all buffered data.

## Timing
- Minimum latency is 2 cycles: a push accepted at edge `t` appears with `out_vld=1` after edge `t+1`.
- Sustained throughput is 1 beat per cycle when `out_rdy=1` and any channel is non-empty.
- Each channel sustains 1 beat per cycle only while it is granted every cycle. Under contention, each requesting channel is granted at least once every `N_CH` grants.
- `in_rdy` and `out_vld` are outputs of registered state only.

## Configuration
- `SUB3_GNT_CNT_EN` defined:
  - `gnt_cnt[i]` increments on each grant to channel `i` and saturates at 16'hFFFF.
  - Cleared only by `rst`.
- `SUB3_GNT_CNT_EN` undefined:
  - The `gnt_cnt` port and counters are absent.
  - All other behaviour is identical.

## Structure
- Package `sub3_pkg`:
  - `ch_w()` function.
  - `GNT_CNT_W=16` constant.
  - `out_state_e` enum (`EMPTY`, `FULL`).
- Sub-module `sub3_skid`: the 2-entry per-channel buffer (push/pop/`cnt`/`rdy`/head data), instantiated `N_CH` times in a generate loop.
- Arbiter, output stage and counters live in `sub3_arb`.

## Test plan
1. Reset, then single push of 8'hA5 on ch1 with `out_rdy=1`: `out_vld` rises 2 cycles after the push, with `out_data=8'hA5`, `out_ch=1`; afterwards all `in_rdy=1`.
2. All 3 channels hold `in_vld=1` continuously with incrementing data and `out_rdy=1`: `out_ch` sequence is 0,1,2,0,1,2…, one beat per cycle, and no data is lost or reordered within any channel.
3. Ch0 pushes 3 beats while `out_rdy=0`: `in_rdy[0]` drops after 2 accepted pushes (plus 1 held in the output stage); `out_data` is stable; releasing `out_rdy` drains the beats in order.
4. Only ch2 active with `rr=0`: ch2 is granted immediately (wrap-around search), and `rr` becomes 0.
5. Assert `rst` mid-stream with 2 beats buffered per channel: `out_vld=0` and all `in_rdy=1` immediately; after release, no stale beats appear.
6. With `SUB3_GNT_CNT_EN`: 70000 grants to ch0 result in `gnt_cnt[0]=16'hFFFF` (saturated) and other counters at their exact grant counts.
